// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// Modulo-MODULUS up/down counter with a synchronous clamped parallel load and
// a registered terminal-count pulse.
//
// Parameters
//   WIDTH    counter width in bits
//   MODULUS  count sequence length, 2 <= MODULUS <= 2**WIDTH
//
// Ports
//   clk    in   1      clock, all state updates on rising edge
//   rst_n  in   1      asynchronous active-low reset (q=0, tc=0)
//   en     in   1      count enable
//   up     in   1      direction: 1 = up, 0 = down
//   load   in   1      synchronous load request, takes priority over en
//   d      in   WIDTH  load value, clamped to MODULUS-1
//   q      out  WIDTH  registered count value
//   tc     out  1      registered terminal-count pulse
//
// Build option
//   UPDOWN_COUNTER_SAT_EN  when defined, the counter saturates at 0 and
//                          MODULUS-1 instead of wrapping; tc then flags an
//                          enabled edge whose step was blocked at a bound.
// -----------------------------------------------------------------------------
module param_updown_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_next;
    logic             tc_next;

    always_comb begin
        q_next  = q;
        tc_next = 1'b0;
        if (load) begin
            // Loads never raise tc, even when the loaded value is a bound.
            q_next = (d > MAX_VAL) ? MAX_VAL : d;
        end else if (en) begin
            if (up) begin
                // >= rather than == keeps q in range even if it were ever corrupted.
                if (q >= MAX_VAL) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                    q_next = MAX_VAL;
`else
                    q_next = '0;
`endif
                    tc_next = 1'b1;
                end else begin
                    q_next = q + 1'b1;
                end
            end else begin
                if (q == '0) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                    q_next = '0;
`else
                    q_next = MAX_VAL;
`endif
                    tc_next = 1'b1;
                end else if (q > MAX_VAL) begin
                    q_next = MAX_VAL;
                end else begin
                    q_next = q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q  <= '0;
            tc <= 1'b0;
        end else begin
            q  <= q_next;
            tc <= tc_next;
        end
    end

endmodule
